// File: rtl/hyper_evt_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : hyper_evt_tracker
//  Purpose  : Event tracker downstream of the HyperBus uDMA macro. Counts
//             end-of-transfer completions, latches maskable pending flags,
//             drives one registered level interrupt and queues completion
//             records in a small FIFO that software pops over the uDMA cfg bus.
//  Ports    : sys_clk_i   - single clock
//             rst_i       - asynchronous active-high reset
//             evt_i[3:0]  - [0] rx chan, [1] tx chan, [2] eot read, [3] eot write
//             cfg_valid_i, cfg_rwn_i, cfg_addr_i[2:0], cfg_data_i[31:0]
//                         - cfg request (rwn: 1 = read, 0 = write)
//             cfg_ready_o, cfg_data_o[31:0]
//                         - cfg response, exactly one cycle after the request
//             irq_o       - registered |(pending & mask)
//  Register map: 0 STATUS, 1 MASK, 2 CNT_RD, 3 CNT_WR, 4 FIFO_POP, 5 CLEAR,
//             6-7 read as zero.
//  Option   : define HYPER_EVT_TRACKER_TIMEOUT_EN to build the channel-event
//             watchdog that drives pending[4]; otherwise pending[4] and
//             MASK[4] are hard-wired to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module hyper_evt_tracker #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic [3:0]  evt_i,
    input  logic        cfg_valid_i,
    input  logic        cfg_rwn_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [31:0] cfg_data_i,
    output logic        cfg_ready_o,
    output logic [31:0] cfg_data_o,
    output logic        irq_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_CNT_RD = 3'd2;
    localparam logic [2:0] ADDR_CNT_WR = 3'd3;
    localparam logic [2:0] ADDR_POP    = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;

    logic [4:0]           pend_q, pend_d;
    logic [4:0]           mask_q, mask_d;
    logic [CNT_WIDTH-1:0] cnt_rd_q, cnt_rd_d;
    logic [CNT_WIDTH-1:0] cnt_wr_q, cnt_wr_d;
    logic                 ovf_q, ovf_d;
    logic [PTR_W-1:0]     wptr_q, rptr_q;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic                 irq_q;
    logic                 rdy_q;
    logic [31:0]          rdata_q, rdata_d;

    logic [1:0]           rec_type_q [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] rec_seq_q  [FIFO_DEPTH];

    logic                 w_req_rd, w_req_wr;
    logic                 w_push, w_pop, w_full, w_drop, w_wr_en;
    logic [1:0]           w_type;
    logic [CNT_WIDTH-1:0] w_seq;
    logic [4:0]           w_clr;
    logic                 w_clr_ovf;
    logic                 w_to_hit;
    logic [4:0]           w_impl_mask;
    logic                 w_unused_ok;

    assign w_req_rd  = cfg_valid_i &  cfg_rwn_i;
    assign w_req_wr  = cfg_valid_i & ~cfg_rwn_i;
    assign w_push    = evt_i[2] | evt_i[3];
    assign w_type    = {evt_i[3], evt_i[2]};
    // Sequence number is the total completions seen before this record.
    assign w_seq     = cnt_rd_q + cnt_wr_q;
    assign w_full    = (fcnt_q == FCNT_W'(FIFO_DEPTH));
    assign w_pop     = w_req_rd && (cfg_addr_i == ADDR_POP) && (fcnt_q != '0);
    // A pop in the same cycle frees a slot, so only an unaccompanied push drops.
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_wr_en   = w_push && !w_drop;
    assign w_clr     = (w_req_wr && cfg_addr_i == ADDR_CLEAR) ? cfg_data_i[4:0] : 5'd0;
    assign w_clr_ovf = w_req_wr && (cfg_addr_i == ADDR_CLEAR) && cfg_data_i[8];

`ifdef HYPER_EVT_TRACKER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic            wd_act_q, wd_act_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    assign w_impl_mask = 5'h1F;
    assign w_unused_ok = ^{cfg_data_i[31:9], cfg_data_i[7:5]};

    // Any eot disarms; a channel event (re)arms from zero; otherwise count
    // while armed and fire once the limit is reached.
    always_comb begin
        wd_act_d = wd_act_q;
        wd_cnt_d = wd_cnt_q;
        w_to_hit = 1'b0;
        if (w_push) begin
            wd_act_d = 1'b0;
            wd_cnt_d = '0;
        end else if (evt_i[0] | evt_i[1]) begin
            wd_act_d = 1'b1;
            wd_cnt_d = '0;
        end else if (wd_act_q) begin
            if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                w_to_hit = 1'b1;
                wd_act_d = 1'b0;
                wd_cnt_d = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_act_q <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            wd_act_q <= wd_act_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign w_to_hit    = 1'b0;
    assign w_impl_mask = 5'h0F;
    // The watchdog limit has no meaning without the watchdog.
    assign w_unused_ok = ^{cfg_data_i[31:9], cfg_data_i[7:5], TIMEOUT_CYC[0]};
`endif

    // State update: a new set always wins over a same-cycle W1C clear.
    always_comb begin
        pend_d   = (pend_q & ~w_clr) | {w_to_hit, evt_i};
        ovf_d    = (ovf_q & ~w_clr_ovf) | w_drop;
        mask_d   = mask_q;
        if (w_req_wr && cfg_addr_i == ADDR_MASK) begin
            mask_d = cfg_data_i[4:0] & w_impl_mask;
        end
        cnt_rd_d = cnt_rd_q + CNT_WIDTH'(evt_i[2]);
        cnt_wr_d = cnt_wr_q + CNT_WIDTH'(evt_i[3]);
        fcnt_d   = fcnt_q + FCNT_W'(w_wr_en) - FCNT_W'(w_pop);
    end

    // Read mux: samples register state as it stands at the request edge.
    always_comb begin
        rdata_d = 32'd0;
        if (w_req_rd) begin
            case (cfg_addr_i)
                ADDR_STATUS: rdata_d = {16'd0, 4'(fcnt_q), 3'd0, ovf_q, 3'd0, pend_q};
                ADDR_MASK:   rdata_d = {27'd0, mask_q};
                ADDR_CNT_RD: rdata_d = 32'(cnt_rd_q);
                ADDR_CNT_WR: rdata_d = 32'(cnt_wr_q);
                ADDR_POP: begin
                    if (fcnt_q != '0) begin
                        rdata_d = 32'h8000_0000 | {14'd0, rec_type_q[rptr_q], 16'd0}
                                | 32'(rec_seq_q[rptr_q]);
                    end
                end
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    // Record storage carries no reset: resetting the pointers empties it.
    always_ff @(posedge sys_clk_i) begin
        if (w_wr_en) begin
            rec_type_q[wptr_q] <= w_type;
            rec_seq_q[wptr_q]  <= w_seq;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q   <= 5'd0;
            mask_q   <= 5'd0;
            cnt_rd_q <= '0;
            cnt_wr_q <= '0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fcnt_q   <= '0;
            irq_q    <= 1'b0;
            rdy_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            cnt_rd_q <= cnt_rd_d;
            cnt_wr_q <= cnt_wr_d;
            ovf_q    <= ovf_d;
            fcnt_q   <= fcnt_d;
            if (w_wr_en) wptr_q <= wptr_q + 1'b1;
            if (w_pop)   rptr_q <= rptr_q + 1'b1;
            irq_q    <= |(pend_q & mask_q);
            rdy_q    <= cfg_valid_i;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_ready_o = rdy_q;
    assign cfg_data_o  = rdata_q;
    assign irq_o       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_hyper_evt_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyper_evt_tracker
//  Purpose  : Self-checking bench for hyper_evt_tracker. A transaction-level
//             model (queue FIFO, integer counters) predicts every response and
//             irq level; directed scenarios pin literal values; a random phase
//             exercises the rest.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hyper_evt_tracker;

    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  evt = 4'd0;
    logic        cfg_valid = 1'b0;
    logic        cfg_rwn = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        cfg_ready_o;
    logic [31:0] cfg_data_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    hyper_evt_tracker #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16), .TIMEOUT_CYC(TO)) dut (
        .sys_clk_i  (clk),
        .rst_i      (rst),
        .evt_i      (evt),
        .cfg_valid_i(cfg_valid),
        .cfg_rwn_i  (cfg_rwn),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_wdata),
        .cfg_ready_o(cfg_ready_o),
        .cfg_data_o (cfg_data_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
`ifdef HYPER_EVT_TRACKER_TIMEOUT_EN
    localparam logic [4:0] IMPL = 5'h1F;
`else
    localparam logic [4:0] IMPL = 5'h0F;
`endif
    logic [4:0]  m_pend, m_mask;
    int          m_rd, m_wr, m_wd_age;
    bit          m_ovf, m_wd_on;
    logic [31:0] m_q[$];
    logic        e_rdy, e_irq;
    logic [31:0] e_data;

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_rd = 0; m_wr = 0; m_ovf = 0;
        m_wd_on = 0; m_wd_age = 0;
        m_q.delete();
        e_rdy = 0; e_data = 0; e_irq = 0;
    endtask

    task automatic model_step();
        logic [31:0] rd;
        logic [4:0]  clr;
        bit          drop, hit, irq_next;
        irq_next = |(m_pend & m_mask);
        rd = 0;
        if (cfg_valid && cfg_rwn) begin
            case (cfg_addr)
                3'd0: rd = 32'(m_pend) | (32'(m_ovf) << 8) | (32'(m_q.size()) << 12);
                3'd1: rd = 32'(m_mask);
                3'd2: rd = 32'(m_rd);
                3'd3: rd = 32'(m_wr);
                3'd4: if (m_q.size() > 0) rd = m_q.pop_front();
                default: rd = 0;
            endcase
        end
        drop = 0;
        if (evt[2] || evt[3]) begin
            if (m_q.size() >= DEPTH) drop = 1;
            else m_q.push_back(32'h8000_0000 | (32'(evt[3:2]) << 16) | 32'((m_rd + m_wr) % 65536));
        end
        hit = 0;
`ifdef HYPER_EVT_TRACKER_TIMEOUT_EN
        if (evt[2] || evt[3]) m_wd_on = 0;
        else if (evt[0] || evt[1]) begin m_wd_on = 1; m_wd_age = 0; end
        else if (m_wd_on) begin
            m_wd_age++;
            if (m_wd_age == TO) begin hit = 1; m_wd_on = 0; end
        end
`endif
        clr = (cfg_valid && !cfg_rwn && cfg_addr == 3'd5) ? cfg_wdata[4:0] : 5'd0;
        m_pend = (m_pend & ~clr) | {hit, evt};
        m_ovf = (m_ovf && !(cfg_valid && !cfg_rwn && cfg_addr == 3'd5 && cfg_wdata[8])) || drop;
        if (cfg_valid && !cfg_rwn && cfg_addr == 3'd1) m_mask = cfg_wdata[4:0] & IMPL;
        if (evt[2]) m_rd = (m_rd + 1) % 65536;
        if (evt[3]) m_wr = (m_wr + 1) % 65536;
        e_rdy = cfg_valid;
        e_data = rd;
        e_irq = irq_next;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    // Compare process: every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        chk("cfg_ready", 32'(cfg_ready_o), 32'(e_rdy));
        chk("cfg_data", cfg_data_o, e_data);
        chk("irq", 32'(irq_o), 32'(e_irq));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1; evt = 0; cfg_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic evt_burst(input logic [3:0] v, input int n);
        @(negedge clk);
        evt = v;
        repeat (n) @(negedge clk);
        evt = 0;
    endtask

    task automatic cfg_op_evt(input logic rwn, input logic [2:0] a, input logic [31:0] d,
                              input logic [3:0] ev, output logic [31:0] r);
        @(negedge clk);
        cfg_valid = 1; cfg_rwn = rwn; cfg_addr = a; cfg_wdata = d; evt = ev;
        @(negedge clk);
        cfg_valid = 0; evt = 0;
        r = cfg_data_o;
        chk("resp_ready", 32'(cfg_ready_o), 32'd1);
    endtask

    task automatic cfg_op(input logic rwn, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] r);
        cfg_op_evt(rwn, a, d, 4'd0, r);
    endtask

    logic [31:0] r;

    initial begin
        do_reset();
        // Reset state.
        cfg_op(1, 3'd0, 0, r);
        chk("reset_status", r, 32'h0);
        chk("reset_irq", 32'(irq_o), 32'd0);

        // Masked eot-read interrupt path.
        cfg_op(0, 3'd1, 32'h4, r);
        evt_burst(4'b0100, 1);
        chk("irq_one_cycle", 32'(irq_o), 32'd0);
        cfg_op(1, 3'd0, 0, r);
        chk("status_eot_rd", r, 32'h0000_1004);
        chk("irq_two_cycle", 32'(irq_o), 32'd1);
        cfg_op(1, 3'd4, 0, r);
        chk("pop_rd_rec", r, 32'h8001_0000);
        cfg_op(0, 3'd5, 32'h4, r);
        chk("irq_at_clear", 32'(irq_o), 32'd1);
        @(negedge clk);
        chk("irq_after_clear", 32'(irq_o), 32'd0);

        // Simultaneous read and write completion.
        do_reset();
        evt_burst(4'b1100, 1);
        cfg_op(1, 3'd2, 0, r);
        chk("cnt_rd_both", r, 32'd1);
        cfg_op(1, 3'd3, 0, r);
        chk("cnt_wr_both", r, 32'd1);
        cfg_op(1, 3'd4, 0, r);
        chk("pop_both", r, 32'h8003_0000);

        // Overflow and drain.
        do_reset();
        evt_burst(4'b1000, 5);
        cfg_op(1, 3'd0, 0, r);
        chk("status_ovf", r, 32'h0000_4108);
        for (int i = 0; i < 4; i++) begin
            cfg_op(1, 3'd4, 0, r);
            chk("pop_seq", r, 32'h8002_0000 | 32'(i));
        end
        cfg_op(1, 3'd4, 0, r);
        chk("pop_empty", r, 32'h0);
        cfg_op(0, 3'd5, 32'h1FF, r);
        evt_burst(4'b1000, 4);
        cfg_op_evt(1, 3'd4, 0, 4'b1000, r);
        chk("pop_push_full", r, 32'h8002_0005);
        cfg_op(1, 3'd0, 0, r);
        chk("status_no_ovf", r, 32'h0000_4008);

        // Unimplemented mask bit and unmapped register.
        cfg_op(0, 3'd1, 32'hFFFF_FFFF, r);
        cfg_op(1, 3'd1, 0, r);
        chk("mask_bits", r, 32'(IMPL));
        cfg_op(0, 3'd6, 32'hFFFF_FFFF, r);
        cfg_op(1, 3'd6, 0, r);
        chk("unmapped", r, 32'h0);

        // Watchdog behaviour.
        do_reset();
        evt_burst(4'b0001, 1);
        repeat (12) @(negedge clk);
        cfg_op(1, 3'd0, 0, r);
`ifdef HYPER_EVT_TRACKER_TIMEOUT_EN
        chk("timeout_set", r, 32'h0000_0011);
        do_reset();
        evt_burst(4'b0001, 1);
        repeat (3) @(negedge clk);
        evt_burst(4'b0100, 1);
        repeat (12) @(negedge clk);
        cfg_op(1, 3'd0, 0, r);
        chk("timeout_cancel", r, 32'h0000_1005);
`else
        chk("no_timeout", r, 32'h0000_0001);
`endif

        // Counter wrap.
        do_reset();
        evt_burst(4'b0100, 65535);
        cfg_op(1, 3'd2, 0, r);
        chk("cnt_rd_max", r, 32'h0000_FFFF);
        evt_burst(4'b0100, 1);
        cfg_op(1, 3'd2, 0, r);
        chk("cnt_rd_wrap", r, 32'h0);

        // Random phase, with one asynchronous reset while a request is in flight.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            evt = 4'($urandom & $urandom);
            cfg_valid = $urandom_range(0, 1) == 1;
            cfg_rwn = $urandom_range(0, 2) != 0;
            cfg_addr = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            cfg_wdata = $urandom;
            if (i == 1500) begin
                cfg_valid = 1;
                #2 rst = 1;
            end
            if (i == 1502) rst = 0;
        end
        @(negedge clk);
        cfg_valid = 0; evt = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
